// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
//   pc_sel_e   : next-PC source selected by the priority logic
//   ras_cnt_w  : width of a return-address-stack occupancy count
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_BR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET,
    SEL_INC
  } pc_sel_e;

  // Count must hold 0..depth inclusive.
  function automatic int unsigned ras_cnt_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/status bundle between decode/execute and the PC sequencer.
//   master : drives stall/branch/jump/call/ret requests and targets, observes PC and RAS status
//   slave  : the sequencer; receives requests, drives pc, redirect, ras_count, ras_ovf, ras_unf
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = 72,
  parameter int unsigned BR_W      = 55,
  parameter int unsigned JMP_W     = 68,
  parameter int unsigned RAS_DEPTH = 8
);

  logic                            stall;
  logic                            branch;
  logic [BR_W-1:0]                 branch_addr;
  logic                            jump;
  logic                            call;
  logic [JMP_W-1:0]                jump_addr;
  logic                            ret;
  logic [PC_W-1:0]                 pc;
  logic                            redirect;
  logic [ras_cnt_w(RAS_DEPTH)-1:0] ras_count;
  logic                            ras_ovf;
  logic                            ras_unf;

  modport master (
    output stall, branch, branch_addr, jump, call, jump_addr, ret,
    input  pc, redirect, ras_count, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, branch, branch_addr, jump, call, jump_addr, ret,
    output pc, redirect, ras_count, ras_ovf, ras_unf
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack (LIFO). A push onto a full stack overwrites the oldest
// entry and the count saturates at Depth. Pop on empty is ignored; callers must check empty_o.
// Ports: clk_i, rst_ni (synchronous, active low), push_i/push_data_i, pop_i,
//        top_o (entry a pop would return), count_o, full_o, empty_o.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned Width = 72,
  parameter int unsigned Depth = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic [Width-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [Width-1:0]            top_o,
  output logic [ras_cnt_w(Depth)-1:0] count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = ras_cnt_w(Depth);

  logic [Width-1:0] mem_q [Depth];
  // ptr_q is the next write slot; the top of stack is one below it (mod Depth).
  logic [PtrW-1:0]  ptr_q, ptr_d, ptr_m1;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign ptr_m1  = ptr_q - PtrW'(1);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[ptr_m1];
  assign count_o = cnt_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PtrW'(1);
      if (!full_o) cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_m1;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential increment, branch, jump, call/return via an
// internal return-address stack, and stall. Priority: reset > stall > branch > jump > call
// > ret > increment. All outputs registered; requests take effect one cycle later.
// Ports: clk, rst_n (synchronous, active low), bus_io (pc_sequencer_if.slave).
// Build option: define PC_REL_BRANCH_EN for pc-relative branches (pc + sign-extended
// branch_addr); otherwise branch_addr is an absolute, zero-extended target.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W      = 72,
  parameter int unsigned     BR_W      = 55,
  parameter int unsigned     JMP_W     = 68,
  parameter int unsigned     RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus_io
);

  pc_sel_e         sel;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, br_target, jmp_target, ras_top;
  logic            redirect_q, redirect_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            ras_full, ras_empty, ret_on_empty;

  assign pc_inc     = pc_q + PC_W'(1);
  assign jmp_target = PC_W'(bus_io.jump_addr);

`ifdef PC_REL_BRANCH_EN
  assign br_target = pc_q + PC_W'($signed(bus_io.branch_addr));
`else
  assign br_target = PC_W'(bus_io.branch_addr);
`endif

  always_comb begin
    sel          = SEL_INC;
    ret_on_empty = 1'b0;
    if (bus_io.stall)       sel = SEL_HOLD;
    else if (bus_io.branch) sel = SEL_BR;
    else if (bus_io.jump)   sel = SEL_JMP;
    else if (bus_io.call)   sel = SEL_CALL;
    else if (bus_io.ret) begin
      // Return with nothing stacked falls through to a plain increment.
      if (ras_empty) ret_on_empty = 1'b1;
      else           sel = SEL_RET;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_BR:   pc_d = br_target;
      SEL_JMP:  pc_d = jmp_target;
      SEL_CALL: pc_d = jmp_target;
      SEL_RET:  pc_d = ras_top;
      SEL_INC:  pc_d = pc_inc;
      default:  pc_d = pc_q;
    endcase
    redirect_d = (sel == SEL_BR) || (sel == SEL_JMP) || (sel == SEL_CALL) || (sel == SEL_RET);
    ovf_d      = ovf_q | ((sel == SEL_CALL) && ras_full);
    unf_d      = unf_q | ret_on_empty;
  end

  pc_ras #(
    .Width(PC_W),
    .Depth(RAS_DEPTH)
  ) u_ras (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (sel == SEL_CALL),
    .push_data_i(pc_inc),
    .pop_i      (sel == SEL_RET),
    .top_o      (ras_top),
    .count_o    (bus_io.ras_count),
    .full_o     (ras_full),
    .empty_o    (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus_io.pc       = pc_q;
  assign bus_io.redirect = redirect_q;
  assign bus_io.ras_ovf  = ovf_q;
  assign bus_io.ras_unf  = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int unsigned PcW   = 72;
  localparam int unsigned BrW   = 55;
  localparam int unsigned JmpW  = 68;
  localparam int unsigned Depth = 8;
  localparam int unsigned CntW  = $clog2(Depth) + 1;
  localparam int unsigned ObsW  = PcW + CntW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PcW), .BR_W(BrW), .JMP_W(JmpW), .RAS_DEPTH(Depth)) bus ();
  pc_sequencer_if #(.PC_W(PcW), .BR_W(BrW), .JMP_W(JmpW), .RAS_DEPTH(Depth)) bus_w ();

  pc_sequencer #(.PC_W(PcW), .BR_W(BrW), .JMP_W(JmpW), .RAS_DEPTH(Depth)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  // Second instance resets to all-ones to observe the wrap to zero.
  pc_sequencer #(.PC_W(PcW), .BR_W(BrW), .JMP_W(JmpW), .RAS_DEPTH(Depth),
                 .RESET_PC({PcW{1'b1}})) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus_w)
  );

  // Reference model: stack as a queue of return addresses, newest at the back.
  logic [PcW-1:0] m_pc;
  logic           m_red, m_ovf, m_unf;
  logic [PcW-1:0] m_q[$];
  logic [ObsW-1:0] mdl;
  wire  [ObsW-1:0] obs = {bus.pc, bus.redirect, bus.ras_count, bus.ras_ovf, bus.ras_unf};

  int n_cmp = 0;
  int n_fail = 0;

  task automatic step(input logic st, input logic br, input logic [BrW-1:0] ba,
                      input logic jp, input logic ca, input logic [JmpW-1:0] ja,
                      input logic rt);
    bus.stall = st; bus.branch = br; bus.branch_addr = ba;
    bus.jump = jp; bus.call = ca; bus.jump_addr = ja; bus.ret = rt;
    @(posedge clk);
    if (!rst_n) begin
      m_pc = '0; m_red = 0; m_ovf = 0; m_unf = 0; m_q.delete();
    end else if (st) begin
      m_red = 0;
    end else if (br) begin
`ifdef PC_REL_BRANCH_EN
      m_pc = m_pc + {{(PcW-BrW){ba[BrW-1]}}, ba};
`else
      m_pc = {{(PcW-BrW){1'b0}}, ba};
`endif
      m_red = 1;
    end else if (jp) begin
      m_pc = {{(PcW-JmpW){1'b0}}, ja}; m_red = 1;
    end else if (ca) begin
      if (m_q.size() == Depth) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
      m_q.push_back(m_pc + 1);
      m_pc = {{(PcW-JmpW){1'b0}}, ja}; m_red = 1;
    end else if (rt && m_q.size() > 0) begin
      m_pc = m_q.pop_back(); m_red = 1;
    end else begin
      if (rt) m_unf = 1;
      m_pc = m_pc + 1; m_red = 0;
    end
    mdl = {m_pc, m_red, CntW'(m_q.size()), m_ovf, m_unf};
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs !== mdl || bus.pc !== '0 || bus.ras_count !== '0) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", obs, mdl);
    end
    for (int i = 1; i <= 4; i++) begin
      idle();
      n_cmp++;
      if (obs !== mdl || bus.pc !== PcW'(i) || bus.redirect !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_inc[%0d]: got pc=%h red=%b want pc=%0d red=0", i, bus.pc,
                 bus.redirect, i);
      end
    end
  endtask

  task automatic test_branch();
    logic [PcW-1:0] want;
    idle();  // pc = 5
`ifdef PC_REL_BRANCH_EN
    step(0, 1, {BrW{1'b1}} - BrW'(1), 0, 0, '0, 0);
    want = PcW'(3);
`else
    step(0, 1, BrW'('h100), 0, 0, '0, 0);
    want = PcW'('h100);
`endif
    n_cmp++;
    if (obs !== mdl || bus.pc !== want || bus.redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL branch: got pc=%h red=%b want pc=%h red=1", bus.pc, bus.redirect, want);
    end
    idle();
    n_cmp++;
    if (obs !== mdl || bus.redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_pulse: got %h want %h", obs, mdl);
    end
  endtask

  task automatic test_call_ret();
    step(0, 0, '0, 1, 0, JmpW'('h10), 0);
    step(0, 0, '0, 0, 1, JmpW'('h40), 0);
    n_cmp++;
    if (obs !== mdl || bus.pc !== PcW'('h40) || bus.ras_count !== CntW'(1)) begin
      n_fail++;
      $display("FAIL call: got pc=%h cnt=%0d want pc=40 cnt=1", bus.pc, bus.ras_count);
    end
    idle(); idle();
    step(0, 0, '0, 0, 0, '0, 1);
    n_cmp++;
    if (obs !== mdl || bus.pc !== PcW'('h11) || bus.ras_count !== '0 || !bus.redirect) begin
      n_fail++;
      $display("FAIL ret: got pc=%h cnt=%0d red=%b want pc=11 cnt=0 red=1", bus.pc,
               bus.ras_count, bus.redirect);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k <= Depth; k++) step(0, 0, '0, 0, 1, JmpW'(k + 1), 0);
    n_cmp++;
    if (obs !== mdl || bus.ras_ovf !== 1'b1 || bus.ras_count !== CntW'(Depth)) begin
      n_fail++;
      $display("FAIL overflow: got ovf=%b cnt=%0d want ovf=1 cnt=%0d", bus.ras_ovf,
               bus.ras_count, Depth);
    end
    for (int k = 0; k < Depth; k++) begin
      step(0, 0, '0, 0, 0, '0, 1);
      n_cmp++;
      if (obs !== mdl || bus.pc !== PcW'(Depth + 1 - k)) begin
        n_fail++;
        $display("FAIL ovf_ret[%0d]: got pc=%h want %0d", k, bus.pc, Depth + 1 - k);
      end
    end
    step(0, 0, '0, 0, 0, '0, 1);
    n_cmp++;
    if (obs !== mdl || bus.pc !== PcW'(3) || bus.ras_unf !== 1'b1 || bus.redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow: got pc=%h unf=%b red=%b want pc=3 unf=1 red=0", bus.pc,
               bus.ras_unf, bus.redirect);
    end
  endtask

  task automatic test_stall();
    logic [PcW-1:0] held;
    held = bus.pc;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, BrW'('h2000), 0, 1, JmpW'('h55), 0);
      n_cmp++;
      if (obs !== mdl || bus.pc !== held || bus.redirect !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: got pc=%h red=%b want pc=%h red=0", i, bus.pc,
                 bus.redirect, held);
      end
    end
    step(0, 1, BrW'('h2000), 0, 0, '0, 0);
    n_cmp++;
    if (obs !== mdl || bus.redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got %h want %h", obs, mdl);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    n_cmp++;
    if (bus_w.pc !== {PcW{1'b1}}) begin
      n_fail++;
      $display("FAIL wrap_reset: got pc=%h want all-ones", bus_w.pc);
    end
    idle();
    n_cmp++;
    if (bus_w.pc !== '0 || bus_w.redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: got pc=%h red=%b want pc=0 red=0", bus_w.pc, bus_w.redirect);
    end
  endtask

  task automatic test_priority();
    step(0, 0, '0, 0, 1, JmpW'('h30), 1);  // call beats ret
    n_cmp++;
    if (obs !== mdl || bus.pc !== PcW'('h30) || bus.ras_count !== CntW'(1)) begin
      n_fail++;
      $display("FAIL call_ret: got pc=%h cnt=%0d want pc=30 cnt=1", bus.pc, bus.ras_count);
    end
    step(0, 1, BrW'('h700), 1, 0, JmpW'('h900), 0);
    n_cmp++;
    if (obs !== mdl) begin
      n_fail++;
      $display("FAIL branch_jump: got %h want %h", obs, mdl);
    end
    step(0, 1, BrW'('h20), 0, 1, JmpW'('h900), 0);  // no push
    n_cmp++;
    if (obs !== mdl || bus.ras_count !== CntW'(1)) begin
      n_fail++;
      $display("FAIL branch_call: got cnt=%0d want 1", bus.ras_count);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, '0, 0, 1, JmpW'('h77), 0);
    step(0, 0, '0, 0, 1, JmpW'('h88), 0);
    do_reset();
    n_cmp++;
    if (obs !== mdl || bus.ras_count !== '0 || bus.ras_ovf !== 1'b0 || bus.ras_unf !== 1'b0
        || bus.pc !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want %h", obs, mdl);
    end
    step(0, 0, '0, 0, 0, '0, 1);
    n_cmp++;
    if (obs !== mdl || bus.ras_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ret: got %h want %h", obs, mdl);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [BrW-1:0]  ba;
      logic [JmpW-1:0] ja;
      ba = BrW'({$urandom, $urandom});
      ja = JmpW'({$urandom, $urandom, $urandom});
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, ba,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, ja,
           $urandom_range(0, 3) == 0);
      rst_n = 1'b1;
      n_cmp++;
      if (obs !== mdl) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, mdl);
      end
    end
  endtask

  initial begin
    bus_w.stall = 0; bus_w.branch = 0; bus_w.branch_addr = '0; bus_w.jump = 0;
    bus_w.call = 0; bus_w.jump_addr = '0; bus_w.ret = 0;
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_stall();
    test_wrap();
    test_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
